acc_multi: RTL and testbench

Parametrised multi-channel accumulator, the successor to the single 8-bit add-and-register accumulator. It holds CHANNELS independent WIDTH-bit accumulators, each with add, subtract, load and clear operations. Results can saturate or wrap, and each channel keeps a sticky overflow flag. It feeds datapath blocks that need per-channel running sums, with a registered result stream plus a side read port for polling.

---
 rtl/acc_multi_if.sv | 32 +++
 rtl/acc_multi.sv | 122 ++++++++++++
 tb/tb_acc_multi.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_multi_if.sv
// acc_multi request/result/side-read bundle.
// master drives requests; slave is the accumulator.
interface acc_multi_if #(
  parameter int WIDTH = 8,
  parameter int CH_W  = 2
);
  logic             in_valid;
  logic [CH_W-1:0]  in_ch;
  logic [1:0]       op;
  logic [WIDTH-1:0] accin;
  logic             cin;
  logic             out_valid;
  logic [CH_W-1:0]  out_ch;
  logic [WIDTH-1:0] accout;
  logic             cout;
  logic             ovf;
  logic [CH_W-1:0]  rd_ch;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ovf;

  modport master (
    output in_valid, in_ch, op, accin, cin, rd_ch,
    input  out_valid, out_ch, accout, cout, ovf,
    input  rd_data, rd_ovf
  );

  modport slave (
    input  in_valid, in_ch, op, accin, cin, rd_ch,
    output out_valid, out_ch, accout, cout, ovf,
    output rd_data, rd_ovf
  );
endinterface

// File: rtl/acc_multi.sv
// Multi-channel accumulator: add/sub/load/clr per channel,
// optional unsigned saturation and sticky overflow flags.
module acc_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int SATURATE = 1
) (
  input logic        clk,
  input logic        clear_n,
  acc_multi_if.slave bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;

  logic [WIDTH-1:0] r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;
  logic             r_out_valid;
  logic [CH_W-1:0]  r_out_ch;
  logic [WIDTH-1:0] r_accout;
  logic             r_cout;
  logic             r_ovf_out;

  logic             w_hit;
  logic [WIDTH-1:0] w_cur;
  logic             w_cur_ovf;
  logic [WIDTH:0]   w_raw;
  logic             w_cout;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf_new;
  logic [WIDTH-1:0] w_rd;
  logic             w_rd_ovf;

  assign w_hit = bus.in_valid &&
    ({1'b0, bus.in_ch} < (CH_W+1)'(CHANNELS));

  always_comb begin
    w_cur     = '0;
    w_cur_ovf = 1'b0;
    w_rd      = '0;
    w_rd_ovf  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.in_ch == CH_W'(i)) begin
        w_cur     = r_acc[i];
        w_cur_ovf = r_ovf[i];
      end
      if (bus.rd_ch == CH_W'(i)) begin
        w_rd     = r_acc[i];
        w_rd_ovf = r_ovf[i];
      end
    end
  end

  always_comb begin
    w_raw     = '0;
    w_cout    = 1'b0;
    w_res     = '0;
    w_ovf_new = 1'b0;
    unique case (bus.op)
      OP_ADD: begin
        w_raw = {1'b0, w_cur} + {1'b0, bus.accin}
              + {{WIDTH{1'b0}}, bus.cin};
        w_cout = w_raw[WIDTH];
        w_res  = (w_cout && SATURATE != 0) ?
                 {WIDTH{1'b1}} : w_raw[WIDTH-1:0];
        w_ovf_new = w_cur_ovf | w_cout;
      end
      OP_SUB: begin
        // bit WIDTH of the extended difference is the borrow
        w_raw = {1'b0, w_cur} - {1'b0, bus.accin}
              - {{WIDTH{1'b0}}, bus.cin};
        w_cout = w_raw[WIDTH];
        w_res  = (w_cout && SATURATE != 0) ?
                 '0 : w_raw[WIDTH-1:0];
        w_ovf_new = w_cur_ovf | w_cout;
      end
      OP_LD: begin
        w_res = bus.accin;
      end
      default: begin
        w_res = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < CHANNELS; i++) r_acc[i] <= '0;
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_accout    <= '0;
      r_cout      <= 1'b0;
      r_ovf_out   <= 1'b0;
    end else begin
      r_out_valid <= w_hit;
      if (w_hit) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (bus.in_ch == CH_W'(i)) begin
            r_acc[i] <= w_res;
            r_ovf[i] <= w_ovf_new;
          end
        end
        r_out_ch  <= bus.in_ch;
        r_accout  <= w_res;
        r_cout    <= w_cout;
        r_ovf_out <= w_ovf_new;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_ch    = r_out_ch;
  assign bus.accout    = r_accout;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf_out;
  assign bus.rd_data   = w_rd;
  assign bus.rd_ovf    = w_rd_ovf;

endmodule

// File: tb/tb_acc_multi.sv
// Bench for acc_multi: saturating, wrapping and 3-channel
// instances share one stimulus stream and a result scoreboard.
module tb_acc_multi;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [1:0] in_ch = '0;
  logic [1:0] op = '0;
  logic [7:0] accin = '0;
  logic       cin = 1'b0;
  logic [1:0] rd_ch = '0;

  acc_multi_if #(.WIDTH(8), .CH_W(2)) b0 ();
  acc_multi_if #(.WIDTH(8), .CH_W(2)) b1 ();
  acc_multi_if #(.WIDTH(8), .CH_W(2)) b2 ();

  acc_multi #(.WIDTH(8), .CHANNELS(4), .CH_W(2), .SATURATE(1))
    u_sat (.clk(clk), .clear_n(clear_n), .bus(b0));
  acc_multi #(.WIDTH(8), .CHANNELS(4), .CH_W(2), .SATURATE(0))
    u_wrap (.clk(clk), .clear_n(clear_n), .bus(b1));
  acc_multi #(.WIDTH(8), .CHANNELS(3), .CH_W(2), .SATURATE(1))
    u_ch3 (.clk(clk), .clear_n(clear_n), .bus(b2));

  assign b0.in_valid = in_valid; assign b1.in_valid = in_valid;
  assign b2.in_valid = in_valid;
  assign b0.in_ch = in_ch; assign b1.in_ch = in_ch;
  assign b2.in_ch = in_ch;
  assign b0.op = op; assign b1.op = op; assign b2.op = op;
  assign b0.accin = accin; assign b1.accin = accin;
  assign b2.accin = accin;
  assign b0.cin = cin; assign b1.cin = cin; assign b2.cin = cin;
  assign b0.rd_ch = rd_ch; assign b1.rd_ch = rd_ch;
  assign b2.rd_ch = rd_ch;

  logic       o_v [3];
  logic [1:0] o_ch [3];
  logic [7:0] o_acc [3];
  logic       o_c [3];
  logic       o_o [3];
  logic [7:0] o_rd [3];
  logic       o_rov [3];

  assign o_v[0] = b0.out_valid; assign o_v[1] = b1.out_valid;
  assign o_v[2] = b2.out_valid;
  assign o_ch[0] = b0.out_ch; assign o_ch[1] = b1.out_ch;
  assign o_ch[2] = b2.out_ch;
  assign o_acc[0] = b0.accout; assign o_acc[1] = b1.accout;
  assign o_acc[2] = b2.accout;
  assign o_c[0] = b0.cout; assign o_c[1] = b1.cout;
  assign o_c[2] = b2.cout;
  assign o_o[0] = b0.ovf; assign o_o[1] = b1.ovf;
  assign o_o[2] = b2.ovf;
  assign o_rd[0] = b0.rd_data; assign o_rd[1] = b1.rd_data;
  assign o_rd[2] = b2.rd_data;
  assign o_rov[0] = b0.rd_ovf; assign o_rov[1] = b1.rd_ovf;
  assign o_rov[2] = b2.rd_ovf;

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic [7:0] acc;
    logic       c;
    logic       o;
  } exp_t;

  exp_t q[$];
  exp_t last [3];
  logic [7:0] m_acc [3][4];
  logic       m_ovf [3][4];
  int  nch [3] = '{4, 4, 3};
  bit  sat [3] = '{1'b1, 1'b0, 1'b1};

  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      last[d] = '{1'b0, 2'd0, 8'd0, 1'b0, 1'b0};
      for (int c = 0; c < 4; c++) begin
        m_acc[d][c] = 8'd0;
        m_ovf[d][c] = 1'b0;
      end
    end
    q.delete();
  endtask

  task automatic check_rd(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_rd%0d", tag, d), 32'(o_rd[d]),
          32'(m_acc[d][rd_ch]));
      chk($sformatf("%s_rov%0d", tag, d), 32'(o_rov[d]),
          32'(m_ovf[d][rd_ch]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_v%0d", tag, d), 32'(o_v[d]), 0);
      chk($sformatf("%s_acc%0d", tag, d), 32'(o_acc[d]), 0);
      chk($sformatf("%s_ch%0d", tag, d), 32'(o_ch[d]), 0);
      chk($sformatf("%s_c%0d", tag, d), 32'(o_c[d]), 0);
      chk($sformatf("%s_o%0d", tag, d), 32'(o_o[d]), 0);
    end
  endtask

  // called at posedge+1; returns at the next posedge+1
  task automatic step(input logic v, input logic [1:0] ch,
                      input logic [1:0] o, input logic [7:0] x,
                      input logic ci);
    logic [8:0] raw;
    logic [7:0] a, res;
    logic       c, ov;
    exp_t       e;
    in_valid = v; in_ch = ch; op = o; accin = x; cin = ci;
    #1;
    check_rd("pre");
    for (int d = 0; d < 3; d++) begin
      e = last[d];
      e.v = 1'b0;
      if (v && int'(ch) < nch[d]) begin
        a = m_acc[d][ch];
        raw = '0; c = 1'b0; ov = 1'b0; res = '0;
        case (o)
          2'd0: begin
            raw = {1'b0, a} + {1'b0, x} + 9'(ci);
            c = raw[8];
            res = (c && sat[d]) ? 8'hFF : raw[7:0];
            ov = m_ovf[d][ch] | c;
          end
          2'd1: begin
            raw = {1'b0, a} - {1'b0, x} - 9'(ci);
            c = raw[8];
            res = (c && sat[d]) ? 8'h00 : raw[7:0];
            ov = m_ovf[d][ch] | c;
          end
          2'd2: res = x;
          default: res = 8'h00;
        endcase
        m_acc[d][ch] = res;
        m_ovf[d][ch] = ov;
        e = '{1'b1, ch, res, c, ov};
      end
      last[d] = e;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (q.size() == 0) begin
        chk("sb_empty", 32'(q.size()), 1);
      end else begin
        e = q.pop_front();
        chk($sformatf("v%0d", d), 32'(o_v[d]), 32'(e.v));
        chk($sformatf("ch%0d", d), 32'(o_ch[d]), 32'(e.ch));
        chk($sformatf("acc%0d", d), 32'(o_acc[d]), 32'(e.acc));
        chk($sformatf("cout%0d", d), 32'(o_c[d]), 32'(e.c));
        chk($sformatf("ovf%0d", d), 32'(o_o[d]), 32'(e.o));
      end
    end
    check_rd("post");
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    model_reset();
    #1;
    check_zero("rst");
    @(posedge clk); @(posedge clk); #1;
    clear_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    check_zero("por");
    @(posedge clk); #1;
    clear_n = 1'b1;

    // carry out of an add: saturate vs wrap
    step(1, 2'd0, 2'd0, 8'hF0, 0);
    chk("t1_first", 32'(o_acc[0]), 32'h0F0);
    step(1, 2'd0, 2'd0, 8'h20, 0);
    chk("t1_sat", 32'(o_acc[0]), 32'h0FF);
    chk("t1_wrap", 32'(o_acc[1]), 32'h010);
    chk("t1_cout", 32'(o_c[1]), 1);

    // subtract with borrow-in, then underflow
    rd_ch = 2'd1;
    step(1, 2'd1, 2'd2, 8'h05, 0);
    step(1, 2'd1, 2'd1, 8'h03, 1);
    chk("t2_sub", 32'(o_acc[0]), 32'h01);
    step(1, 2'd1, 2'd1, 8'h02, 0);
    chk("t2_sat", 32'(o_acc[0]), 32'h00);
    chk("t2_wrap", 32'(o_acc[1]), 32'hFF);
    chk("t2_rovf", 32'(o_rov[0]), 1);
    step(0, 2'd0, 2'd0, 8'h00, 0);

    // back-to-back, interleaved channels
    do_reset();
    step(1, 2'd0, 2'd0, 8'h01, 0);
    step(1, 2'd1, 2'd0, 8'h02, 0);
    step(1, 2'd0, 2'd0, 8'h03, 0);
    chk("t3_chain", 32'(o_acc[0]), 32'h04);
    step(1, 2'd0, 2'd0, 8'hFF, 1);
    chk("t3_satff", 32'(o_acc[0]), 32'hFF);
    chk("t3_wrap", 32'(o_acc[1]), 32'h04);

    // clear with concurrent side read
    rd_ch = 2'd2;
    step(1, 2'd2, 2'd0, 8'hFF, 0);
    step(1, 2'd2, 2'd0, 8'h02, 0);
    chk("t4_setovf", 32'(o_rov[0]), 1);
    step(1, 2'd2, 2'd3, 8'h55, 1);
    chk("t4_rd", 32'(o_rd[0]), 0);
    chk("t4_rovf", 32'(o_rov[0]), 0);
    chk("t4_cout", 32'(o_c[0]), 0);

    // async reset mid-stream
    step(1, 2'd1, 2'd0, 8'h33, 0);
    in_valid = 1'b1; in_ch = 2'd1; op = 2'd0; accin = 8'h44;
    #2;
    clear_n = 1'b0;
    model_reset();
    #1;
    check_zero("mid");
    for (int c = 0; c < 4; c++) begin
      rd_ch = 2'(c);
      #1;
      check_rd("mid");
    end
    @(posedge clk); #1;
    check_zero("hold");
    in_valid = 1'b0;
    clear_n = 1'b1;
    step(1, 2'd3, 2'd0, 8'h07, 0);
    chk("t5_ch3", 32'(o_acc[0]), 32'h07);
    chk("t5_drop", 32'(o_v[2]), 0);

    // out-of-range channel on the 3-channel instance
    rd_ch = 2'd3;
    step(1, 2'd3, 2'd0, 8'h11, 0);
    chk("t6_drop", 32'(o_v[2]), 0);
    rd_ch = 2'd2;
    step(1, 2'd2, 2'd0, 8'h11, 0);
    chk("t6_ch2", 32'(o_acc[2]), 32'h11);

    for (int i = 0; i < 60; i++) begin
      rd_ch = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 4) != 0),
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end
    step(0, 2'd0, 2'd0, 8'h00, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
